// File: rtl/mole_spawn_scheduler_pkg.sv
// Shared constants and helpers for the whack-a-mole spawn scheduler:
// level encoding, LFSR tap mask, level-based selection and popcount.
package mole_pkg;

  localparam logic [1:0] LVL_EASY = 2'd0;
  localparam logic [1:0] LVL_MED  = 2'd1;
  localparam logic [1:0] LVL_HARD = 2'd2;

  // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from bits 7,5,4,3
  localparam logic [7:0] LFSR_TAP_MASK = 8'hB8;

  localparam int CNT_W = 16;

  function automatic int unsigned sel_by_level(input logic [1:0] lvl,
                                               input int unsigned easy,
                                               input int unsigned med,
                                               input int unsigned hard);
    int unsigned r;
    case (lvl)
      LVL_EASY: r = easy;
      LVL_MED:  r = med;
      default:  r = hard;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/mole_spawn_scheduler_if.sv
// Game-side bundle of the spawn scheduler: control/hit inputs, LED and event outputs.
interface mole_spawn_scheduler_if #(
  parameter int NUM_HOLES = 5
);
  logic                 enable;
  logic [1:0]           level;
  logic [NUM_HOLES-1:0] hit_vec;
  logic [NUM_HOLES-1:0] mole_led;
  logic                 hit_pulse;
  logic [2:0]           hit_count;
  logic                 timeout_pulse;
  logic                 miss_pulse;
  logic [3:0]           active_count;

  modport master (
    output enable, level, hit_vec,
    input  mole_led, hit_pulse, hit_count, timeout_pulse, miss_pulse, active_count
  );

  modport slave (
    input  enable, level, hit_vec,
    output mole_led, hit_pulse, hit_count, timeout_pulse, miss_pulse, active_count
  );
endinterface

// File: rtl/mole_spawn_scheduler_lfsr8.sv
// 8-bit Fibonacci LFSR, advances while en is high, synchronous reset to SEED.
module mole_lfsr8
  import mole_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [7:0] q
);

  logic [7:0] q_r;
  logic       fb_s;

  // feedback bit from the tap mask
  always_comb begin
    fb_s = ^(q_r & LFSR_TAP_MASK);
  end

  // shift register state
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= SEED;
    end else if (en) begin
      q_r <= {q_r[6:0], fb_s};
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/mole_spawn_scheduler.sv
// Multi-mole spawn scheduler: tick generation, spawn timing, per-hole lifetimes,
// hit/timeout resolution. Optional miss detection under MOLE_SCHED_MISS_EN.
module mole_spawn_scheduler
  import mole_pkg::*;
#(
  parameter int          NUM_HOLES  = 5,
  parameter int          MAX_ACTIVE = 2,
  parameter int          TICK_DIV   = 1_000_000,
  parameter int          LIFE_EASY  = 300,
  parameter int          LIFE_MED   = 200,
  parameter int          LIFE_HARD  = 100,
  parameter int          SPAWN_EASY = 150,
  parameter int          SPAWN_MED  = 100,
  parameter int          SPAWN_HARD = 50,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic                    clk,
  input  logic                    reset,
  mole_spawn_scheduler_if.slave   bus
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TICK_W-1:0]    tick_cnt_r;
  logic                 en_d_r;
  logic [CNT_W-1:0]     spawn_timer_r;
  logic [CNT_W-1:0]     life_r [NUM_HOLES];
  logic [NUM_HOLES-1:0] led_r;
  logic                 hit_pulse_r;
  logic [2:0]           hit_count_r;
  logic                 timeout_pulse_r;
  logic [3:0]           active_count_r;
  logic [7:0]           lfsr_s;

  logic                 tick_s;
  logic [NUM_HOLES-1:0] hit_mask_s;
  logic [NUM_HOLES-1:0] expire_mask_s;
  logic [NUM_HOLES-1:0] timeout_mask_s;
  logic [NUM_HOLES-1:0] clear_mask_s;
  logic [NUM_HOLES-1:0] avail_mask_s;
  logic [NUM_HOLES-1:0] spawn_mask_s;
  logic [NUM_HOLES-1:0] led_next_s;
  logic                 spawn_allow_s;
  logic                 spawn_s;
  logic [CNT_W-1:0]     life_sel_s;
  logic [CNT_W-1:0]     spawn_sel_s;
  int                   start_s;
  int                   idx_s;

  mole_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (bus.enable),
    .q     (lfsr_s)
  );

  // event resolution and hole selection for the coming edge
  always_comb begin
    tick_s         = bus.enable && (tick_cnt_r == TICK_W'(TICK_DIV - 1));
    life_sel_s     = CNT_W'(sel_by_level(bus.level, LIFE_EASY, LIFE_MED, LIFE_HARD));
    spawn_sel_s    = CNT_W'(sel_by_level(bus.level, SPAWN_EASY, SPAWN_MED, SPAWN_HARD));
    hit_mask_s     = bus.hit_vec & led_r;
    expire_mask_s  = '0;
    for (int h = 0; h < NUM_HOLES; h++) begin
      expire_mask_s[h] = tick_s && led_r[h] && (life_r[h] == CNT_W'(1));
    end
    // a hit on an expiring hole takes precedence over the timeout
    timeout_mask_s = expire_mask_s & ~hit_mask_s;
    clear_mask_s   = hit_mask_s | timeout_mask_s;
    avail_mask_s   = ~led_r & ~clear_mask_s;
    spawn_allow_s  = en_d_r && (spawn_timer_r == CNT_W'(0)) &&
                     (active_count_r < 4'(MAX_ACTIVE));
    start_s        = int'(lfsr_s) % NUM_HOLES;
    idx_s          = 0;
    spawn_mask_s   = '0;
    spawn_s        = 1'b0;
    for (int i = 0; i < NUM_HOLES; i++) begin
      idx_s               = (start_s + i) % NUM_HOLES;
      spawn_mask_s[idx_s] = spawn_allow_s && !spawn_s && avail_mask_s[idx_s];
      spawn_s             = spawn_s | spawn_mask_s[idx_s];
    end
    led_next_s     = (led_r & ~clear_mask_s) | spawn_mask_s;
  end

  // scheduler state and registered outputs
  always_ff @(posedge clk) begin
    if (reset || !bus.enable) begin
      tick_cnt_r      <= '0;
      en_d_r          <= 1'b0;
      spawn_timer_r   <= '0;
      led_r           <= '0;
      hit_pulse_r     <= 1'b0;
      hit_count_r     <= 3'd0;
      timeout_pulse_r <= 1'b0;
      active_count_r  <= 4'd0;
      for (int h = 0; h < NUM_HOLES; h++) begin
        life_r[h] <= '0;
      end
    end else begin
      tick_cnt_r <= tick_s ? '0 : tick_cnt_r + TICK_W'(1);
      en_d_r     <= 1'b1;
      if (!en_d_r || spawn_s) begin
        spawn_timer_r <= spawn_sel_s;
      end else if (tick_s && (spawn_timer_r != CNT_W'(0))) begin
        spawn_timer_r <= spawn_timer_r - CNT_W'(1);
      end else begin
        spawn_timer_r <= spawn_timer_r;
      end
      for (int h = 0; h < NUM_HOLES; h++) begin
        if (spawn_mask_s[h]) begin
          life_r[h] <= life_sel_s;
        end else if (clear_mask_s[h]) begin
          life_r[h] <= '0;
        end else if (tick_s && led_r[h]) begin
          life_r[h] <= life_r[h] - CNT_W'(1);
        end else begin
          life_r[h] <= life_r[h];
        end
      end
      led_r           <= led_next_s;
      hit_pulse_r     <= |hit_mask_s;
      hit_count_r     <= 3'(popcount8(8'(hit_mask_s)));
      timeout_pulse_r <= |timeout_mask_s;
      active_count_r  <= popcount8(8'(led_next_s));
    end
  end

`ifdef MOLE_SCHED_MISS_EN
  logic miss_pulse_r;

  // strike on a dark hole; no effect on slots
  always_ff @(posedge clk) begin
    if (reset || !bus.enable) begin
      miss_pulse_r <= 1'b0;
    end else begin
      miss_pulse_r <= |(bus.hit_vec & ~led_r);
    end
  end

  assign bus.miss_pulse = miss_pulse_r;
`else
  assign bus.miss_pulse = 1'b0;
`endif

  assign bus.mole_led      = led_r;
  assign bus.hit_pulse     = hit_pulse_r;
  assign bus.hit_count     = hit_count_r;
  assign bus.timeout_pulse = timeout_pulse_r;
  assign bus.active_count  = active_count_r;

endmodule

// File: tb/tb_mole_spawn_scheduler.sv
// Randomized scoreboard bench for mole_spawn_scheduler against a behavioural game model.
module tb_mole_spawn_scheduler;

  localparam int NH = 5;
  localparam int MA = 2;
  localparam int TD = 4;
  localparam int L_E = 10, L_M = 6, L_H = 3;
  localparam int S_E = 5,  S_M = 4, S_H = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mole_spawn_scheduler_if #(.NUM_HOLES(NH)) bus ();

  mole_spawn_scheduler #(
    .NUM_HOLES(NH), .MAX_ACTIVE(MA), .TICK_DIV(TD),
    .LIFE_EASY(L_E), .LIFE_MED(L_M), .LIFE_HARD(L_H),
    .SPAWN_EASY(S_E), .SPAWN_MED(S_M), .SPAWN_HARD(S_H),
    .LFSR_SEED(8'hA5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [NH-1:0] led;
    logic          hp;
    logic [2:0]    hc;
    logic          tp;
    logic          mp;
    logic [3:0]    ac;
  } obs_t;

  obs_t exp_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  // game model: cycles-into-tick, spawn countdown, per-hole remaining life
  int m_cyc, m_en_d, m_timer, m_lfsr;
  int m_life[NH];
  bit m_led[NH];

  function automatic int by_level(input int lvl, input int e, input int m, input int h);
    if (lvl == 0) return e;
    if (lvl == 1) return m;
    return h;
  endfunction

  function automatic void model_step(input bit rst, input bit en, input int lvl,
                                     input logic [NH-1:0] hv);
    obs_t e;
    int   hits, tos, lit, pick, start, hh, fb;
    bit   tick, miss;
    int   lfsr_now;
    bit   hit_b[NH];
    bit   to_b[NH];
    e = '0;
    if (rst || !en) begin
      m_cyc = 0; m_en_d = 0; m_timer = 0;
      if (rst) m_lfsr = 'hA5;
      for (int h = 0; h < NH; h++) begin m_life[h] = 0; m_led[h] = 0; end
    end else begin
      tick     = (m_cyc == TD - 1);
      m_cyc    = (m_cyc + 1) % TD;
      lfsr_now = m_lfsr;
      fb       = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
      m_lfsr   = ((m_lfsr << 1) | fb) & 255;
      lit = 0; hits = 0; tos = 0; miss = 0;
      for (int h = 0; h < NH; h++) begin
        lit     += m_led[h];
        hit_b[h] = m_led[h] && hv[h];
        to_b[h]  = m_led[h] && !hit_b[h] && tick && (m_life[h] == 1);
        hits    += hit_b[h];
        tos     += to_b[h];
        if (hv[h] && !m_led[h]) miss = 1;
      end
      pick = -1;
      if (m_en_d && m_timer == 0 && lit < MA) begin
        start = lfsr_now % NH;
        for (int k = 0; k < NH; k++) begin
          hh = (start + k) % NH;
          if (pick < 0 && !m_led[hh]) pick = hh;
        end
      end
      for (int h = 0; h < NH; h++) begin
        if (hit_b[h] || to_b[h]) m_led[h] = 0;
        else if (m_led[h] && tick) m_life[h] -= 1;
      end
      if (pick >= 0) begin
        m_led[pick]  = 1;
        m_life[pick] = by_level(lvl, L_E, L_M, L_H);
      end
      if (!m_en_d || pick >= 0) m_timer = by_level(lvl, S_E, S_M, S_H);
      else if (tick && m_timer > 0) m_timer -= 1;
      m_en_d = 1;
      e.hp = (hits > 0);
      e.hc = 3'(hits);
      e.tp = (tos > 0);
`ifdef MOLE_SCHED_MISS_EN
      e.mp = miss;
`else
      e.mp = 1'b0;
`endif
      for (int h = 0; h < NH; h++) begin
        e.led[h] = m_led[h];
        e.ac     = e.ac + 4'(m_led[h]);
      end
    end
    exp_q.push_back(e);
  endfunction

  // monitor: one registered observation per clock edge
  always @(posedge clk) begin
    obs_t e;
    obs_t a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.mole_led, bus.hit_pulse, bus.hit_count, bus.timeout_pulse,
           bus.miss_pulse, bus.active_count};
      chk_cnt++;
      if (a === e) pass_cnt++;
      else $display("FAIL obs t=%0t got led=%b hp=%b hc=%0d tp=%b mp=%b ac=%0d want led=%b hp=%b hc=%0d tp=%b mp=%b ac=%0d",
                    $time, a.led, a.hp, a.hc, a.tp, a.mp, a.ac,
                    e.led, e.hp, e.hc, e.tp, e.mp, e.ac);
    end
  end

  task automatic drive(input bit rst, input bit en, input int lvl, input logic [NH-1:0] hv);
    @(negedge clk);
    reset       = rst;
    bus.enable  = en;
    bus.level   = 2'(lvl);
    bus.hit_vec = hv;
    model_step(rst, en, lvl, hv);
  endtask

  initial begin
    logic [NH-1:0] hv;
    logic [NH-1:0] lit_v;
    int            lvl;
    bit            en;
    int            off_left;
    reset = 1'b1; bus.enable = 1'b0; bus.level = 2'd0; bus.hit_vec = '0;
    m_lfsr = 'hA5;
    drive(1, 0, 0, '0);
    drive(1, 0, 0, '0);
    @(negedge clk);
    chk_cnt++;
    if (dut.u_lfsr.q === 8'hA5) pass_cnt++;
    else $display("FAIL lfsr_reset got %h want a5", dut.u_lfsr.q);

    // quiet easy game first: spawn, then natural timeout
    for (int c = 0; c < 120; c++) drive(0, 1, 0, '0);
    // hard game without hits: slot saturation and deferred spawns
    for (int c = 0; c < 150; c++) drive(0, 1, 2, '0);

    lvl = 0; en = 1; off_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 299) == 0) lvl = $urandom_range(0, 3);
      if (off_left > 0) begin
        off_left--;
        en = (off_left == 0);
      end else if ($urandom_range(0, 399) == 0) begin
        off_left = $urandom_range(1, 5);
        en = 0;
      end
      for (int h = 0; h < NH; h++) lit_v[h] = m_led[h];
      hv = '0;
      if (en && m_cyc == TD - 1 && $urandom_range(0, 1) == 1) begin
        for (int h = 0; h < NH; h++) hv[h] = m_led[h] && (m_life[h] == 1);
      end
      if (hv == '0) begin
        case ($urandom_range(0, 15))
          0:       hv = lit_v;
          1:       hv = NH'($urandom);
          2:       hv = NH'(1) << $urandom_range(0, NH - 1);
          default: hv = '0;
        endcase
      end
      if ($urandom_range(0, 799) == 0) begin
        drive(1, en, lvl, hv);
        @(negedge clk);
        chk_cnt++;
        if (dut.u_lfsr.q === 8'hA5) pass_cnt++;
        else $display("FAIL lfsr_midreset got %h want a5", dut.u_lfsr.q);
      end else begin
        drive(0, en, lvl, hv);
      end
    end
    for (int c = 0; c < 4; c++) drive(0, 0, 0, NH'(1));

    for (int c = 0; c < 20 && exp_q.size() > 0; c++) @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL drain got %0d pending want 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mole_spawn_scheduler.md
Name: mole_spawn_scheduler

Overview:
- Multi-mole scheduler for the whack-a-mole LED datapath.
- Decides when and where moles appear, tracks each lit hole's lifetime, and resolves hits and timeouts into single-cycle events.
- Supports up to MAX_ACTIVE concurrent moles. Difficulty sets both lifetime and spawn interval.
- Sits between the game-control FSM (enable, level) and the score counter / LED outputs. Consumes the qualified per-hole hit vector.

Parameters:
- NUM_HOLES, 5, number of holes/LEDs (2..8).
- MAX_ACTIVE, 2, maximum simultaneously lit holes (1..NUM_HOLES).
- TICK_DIV, 1_000_000, clk cycles per scheduler tick (10 ms at 100 MHz).
- LIFE_EASY / LIFE_MED / LIFE_HARD, 300 / 200 / 100, mole lifetime in ticks.
- SPAWN_EASY / SPAWN_MED / SPAWN_HARD, 150 / 100 / 50, ticks between spawn attempts.
- LFSR_SEED, 8'hA5, nonzero LFSR reset value.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high reset.
- enable, input, 1, game running (from FSM).
- level, input, 2, difficulty: 0 easy, 1 med, 2 hard, 3 treated as hard.
- hit_vec, input, NUM_HOLES, one-cycle per-hole hit strobes.
- mole_led, output, NUM_HOLES, lit holes.
- hit_pulse, output, 1, one cycle when ≥1 lit hole is hit.
- hit_count, output, 3, number of holes hit in that event (valid with hit_pulse).
- timeout_pulse, output, 1, one cycle when ≥1 mole expires.
- miss_pulse, output, 1, hit on a dark hole (optional feature).
- active_count, output, 4, popcount of mole_led.

Behaviour:
- Reset: all outputs 0, all counters 0, LFSR = LFSR_SEED. Reset asserted mid-game returns to this state on the next edge.
- Tick generator: counts 0..TICK_DIV-1 while enable; tick strobe on wrap.
- enable low: counter, slots and LED cleared next cycle; no pulses; LFSR holds.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every cycle while enable.
- Spawn timer:
  - Loaded with SPAWN_x on the enable rising edge and after each successful spawn.
  - Decrements on tick; sticks at 0 while active_count == MAX_ACTIVE.
  - When 0 and a slot is free, spawns on the next cycle (pending spawn deferred, not dropped).
- Hole selection:
  - start = lfsr % NUM_HOLES.
  - Circular upward search for the first hole that is dark and not being cleared this cycle.
  - Lifetime LIFE_x is latched per hole at spawn; level changes affect only later spawns.
- Lifetime: per-hole counter decrements on tick. Reaching 0 clears the LED and asserts timeout_pulse in the same registered cycle.
- Hit: hit_vec & mole_led sampled in cycle N. In cycle N+1 those bits are clear, hit_pulse = 1, and hit_count = popcount.
- Simultaneous events:
  - Hit and timeout on the same hole in the same cycle: hit wins, no timeout.
  - Hit on one hole and timeout on another: both pulses.
  - Spawn and clear in the same cycle: the spawn cannot reuse a hole cleared that cycle.
- Every pulse is exactly one cycle. No pulses are generated while enable = 0.

Optional Feature:
- MOLE_SCHED_MISS_EN defined: miss_pulse = 1 in cycle N+1 when hit_vec & ~mole_led is nonzero in cycle N. A miss does not affect slots. Simultaneous hit and miss assert both pulses.
- Undefined: miss_pulse tied 0, no miss logic. The port is always present.

Decomposition:
- Package mole_pkg:
  - Level encoding constants (LVL_EASY/MED/HARD).
  - LFSR tap mask.
  - Function selecting lifetime/spawn interval by level.
  - popcount function.
- Sub-module mole_lfsr8: 8-bit LFSR with enable and seed parameter.
- Tick generator, slot counters, spawn logic and pulse registers stay in the top module.

Test Plan:
All scenarios use TICK_DIV=4, LIFE_*=10/6/3, SPAWN_*=5/4/2, MAX_ACTIVE=2, NUM_HOLES=5.
1. Reset, enable=1, level=0: first LED lights 5 ticks (~20 cycles) after enable. With no hit, timeout_pulse fires 10 ticks later and that LED clears.
2. Level 2, no hits: active_count never exceeds 2. The third spawn is deferred until a timeout frees a slot, then occurs on the next cycle.
3. Hole 3 lit, hit_vec=5'b01000 at cycle N: cycle N+1 has mole_led[3]=0, hit_pulse=1, hit_count=1, with no timeout_pulse in any later cycle.
4. Hit_vec strobe on the tick where hole 3's lifetime reaches 0: hit_pulse=1, timeout_pulse=0. Two lit holes hit together give hit_count=2.
5. Drop enable mid-game: mole_led=0 next cycle, no pulses. Assert reset mid-lifetime: all outputs 0 and LFSR=8'hA5 next cycle.
6. MOLE_SCHED_MISS_EN defined, hit_vec=5'b00001 on a dark hole 0: miss_pulse=1 for one cycle, hit_pulse=0. Undefined: miss_pulse stays 0.
